// File: rtl/pipe_pkg.sv
// Shared types for the RV32I pipeline-register bank.
// Stage bundles, bubble constants and the NOP encoding.
package pipe_pkg;

  localparam int PIPE_XLEN = 32;

  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

  typedef struct packed {
    logic       reg_write;
    logic [1:0] result_src;
    logic       mem_write;
    logic       jump;
    logic       branch;
    logic       alu_src;
    logic [2:0] alu_control;
  } ctrl_t;

  localparam ctrl_t CTRL_BUBBLE = '0;

  typedef struct packed {
    logic [PIPE_XLEN-1:0] rd1;
    logic [PIPE_XLEN-1:0] rd2;
    logic [PIPE_XLEN-1:0] imm_ext;
    logic [PIPE_XLEN-1:0] pc;
    logic [PIPE_XLEN-1:0] pc_plus4;
  } idex_t;

  typedef struct packed {
    logic [PIPE_XLEN-1:0] alu_result;
    logic [PIPE_XLEN-1:0] write_data;
    logic [PIPE_XLEN-1:0] pc_plus4;
  } exmem_t;

  typedef struct packed {
    logic [PIPE_XLEN-1:0] alu_result;
    logic [PIPE_XLEN-1:0] read_data;
    logic [PIPE_XLEN-1:0] pc_plus4;
  } memwb_t;

  typedef struct packed {
    logic                 valid;
    logic [31:0]          instr;
    logic [PIPE_XLEN-1:0] pc;
    logic [PIPE_XLEN-1:0] pc_plus4;
  } if_id_t;

  typedef struct packed {
    logic       valid;
    ctrl_t      ctrl;
    idex_t      data;
    logic [4:0] rs1;
    logic [4:0] rs2;
    logic [4:0] rd;
  } id_ex_t;

  typedef struct packed {
    logic       valid;
    ctrl_t      ctrl;
    exmem_t     data;
    logic [4:0] rd;
  } ex_mem_t;

  typedef struct packed {
    logic       valid;
    ctrl_t      ctrl;
    memwb_t     data;
    logic [4:0] rd;
  } mem_wb_t;

  localparam if_id_t IF_ID_BUBBLE = '{
    valid:    1'b0,
    instr:    NOP_INSTR,
    pc:       '0,
    pc_plus4: '0
  };

endpackage

// File: rtl/pipe_reg.sv
// Generic stage register with clear-over-enable priority.
// Clear loads RST_VAL; enable low holds the current contents.
module pipe_reg #(
  parameter int               WIDTH   = 32,
  parameter logic [WIDTH-1:0] RST_VAL = '0
) (
  input  logic             clk,
  input  logic             clr,
  input  logic             en,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  always_ff @(posedge clk) begin
    if (clr) begin
      q <= RST_VAL;
    end else if (en) begin
      q <= d;
    end
  end

endmodule

// File: rtl/pipe_stage_regs.sv
// PC, IF/ID, ID/EX, EX/MEM and MEM/WB registers of the RV32I core.
// Define PIPE_PERF_CNT_EN to build the stall/flush/retire counters.
module pipe_stage_regs
  import pipe_pkg::*;
#(
  parameter int              XLEN     = 32,
  parameter logic [XLEN-1:0] RESET_PC = 32'h0000_0000
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [XLEN-1:0] PCNextF,
  input  logic [31:0]     InstrF,
  input  logic            StallF,
  input  logic            StallD,
  input  logic            FlushD,
  input  logic            FlushE,
  input  ctrl_t           CtrlD,
  input  idex_t           DataD,
  input  exmem_t          DataE,
  input  logic [XLEN-1:0] ReadDataM,
  output logic [XLEN-1:0] PCF,
  output logic [31:0]     InstrD,
  output logic [XLEN-1:0] PCD,
  output logic [XLEN-1:0] PCPlus4D,
  output logic [4:0]      Rs1D,
  output logic [4:0]      Rs2D,
  output logic [4:0]      RdD,
  output ctrl_t           CtrlE,
  output idex_t           DataE_q,
  output ctrl_t           CtrlM,
  output exmem_t          DataM,
  output ctrl_t           CtrlW,
  output memwb_t          DataW,
  output logic [4:0]      Rs1E,
  output logic [4:0]      Rs2E,
  output logic [4:0]      RdE,
  output logic [4:0]      RdM,
  output logic [4:0]      RdW,
  output logic            RegWriteM,
  output logic            RegWriteW,
  output logic            ResultSrcE0,
  output logic            ValidD,
  output logic            ValidE,
  output logic            ValidM,
  output logic            ValidW,
  output logic [31:0]     PerfCycles,
  output logic [31:0]     PerfStalls,
  output logic [31:0]     PerfFlushes,
  output logic [31:0]     PerfRetired
);

  if_id_t  ifid_d,  ifid_q;
  id_ex_t  idex_d,  idex_q;
  ex_mem_t exmem_d, exmem_q;
  mem_wb_t memwb_d, memwb_q;

  pipe_reg #(
    .WIDTH   (XLEN),
    .RST_VAL (RESET_PC)
  ) u_pc (
    .clk (clk),
    .clr (reset),
    .en  (~StallF),
    .d   (PCNextF),
    .q   (PCF)
  );

  assign ifid_d = '{
    valid:    1'b1,
    instr:    InstrF,
    pc:       PCF,
    pc_plus4: PCF + XLEN'(4)
  };

  pipe_reg #(
    .WIDTH   ($bits(if_id_t)),
    .RST_VAL (IF_ID_BUBBLE)
  ) u_if_id (
    .clk (clk),
    .clr (reset | FlushD),
    .en  (~StallD),
    .d   (ifid_d),
    .q   (ifid_q)
  );

  assign InstrD   = ifid_q.instr;
  assign PCD      = ifid_q.pc;
  assign PCPlus4D = ifid_q.pc_plus4;
  assign ValidD   = ifid_q.valid;
  assign Rs1D     = ifid_q.instr[19:15];
  assign Rs2D     = ifid_q.instr[24:20];
  assign RdD      = ifid_q.instr[11:7];

  // Load-use stalls arrive here as FlushE, so ID/EX never holds.
  assign idex_d = '{
    valid: ValidD,
    ctrl:  CtrlD,
    data:  DataD,
    rs1:   Rs1D,
    rs2:   Rs2D,
    rd:    RdD
  };

  pipe_reg #(
    .WIDTH   ($bits(id_ex_t)),
    .RST_VAL ('0)
  ) u_id_ex (
    .clk (clk),
    .clr (reset | FlushE),
    .en  (1'b1),
    .d   (idex_d),
    .q   (idex_q)
  );

  assign CtrlE       = idex_q.ctrl;
  assign DataE_q     = idex_q.data;
  assign Rs1E        = idex_q.rs1;
  assign Rs2E        = idex_q.rs2;
  assign RdE         = idex_q.rd;
  assign ValidE      = idex_q.valid;
  assign ResultSrcE0 = idex_q.ctrl.result_src[0];

  assign exmem_d = '{
    valid: idex_q.valid,
    ctrl:  idex_q.ctrl,
    data:  DataE,
    rd:    idex_q.rd
  };

  pipe_reg #(
    .WIDTH   ($bits(ex_mem_t)),
    .RST_VAL ('0)
  ) u_ex_mem (
    .clk (clk),
    .clr (reset),
    .en  (1'b1),
    .d   (exmem_d),
    .q   (exmem_q)
  );

  assign CtrlM     = exmem_q.ctrl;
  assign DataM     = exmem_q.data;
  assign RdM       = exmem_q.rd;
  assign ValidM    = exmem_q.valid;
  assign RegWriteM = exmem_q.ctrl.reg_write;

  assign memwb_d = '{
    valid: exmem_q.valid,
    ctrl:  exmem_q.ctrl,
    data:  '{
      alu_result: exmem_q.data.alu_result,
      read_data:  ReadDataM,
      pc_plus4:   exmem_q.data.pc_plus4
    },
    rd:    exmem_q.rd
  };

  pipe_reg #(
    .WIDTH   ($bits(mem_wb_t)),
    .RST_VAL ('0)
  ) u_mem_wb (
    .clk (clk),
    .clr (reset),
    .en  (1'b1),
    .d   (memwb_d),
    .q   (memwb_q)
  );

  assign CtrlW     = memwb_q.ctrl;
  assign DataW     = memwb_q.data;
  assign RdW       = memwb_q.rd;
  assign ValidW    = memwb_q.valid;
  assign RegWriteW = memwb_q.ctrl.reg_write;

`ifdef PIPE_PERF_CNT_EN
  logic [31:0] perf_cycles_q;
  logic [31:0] perf_stalls_q;
  logic [31:0] perf_flushes_q;
  logic [31:0] perf_retired_q;

  // A cycle flushing both D and E still counts as one flush event.
  always_ff @(posedge clk) begin
    if (reset) begin
      perf_cycles_q  <= '0;
      perf_stalls_q  <= '0;
      perf_flushes_q <= '0;
      perf_retired_q <= '0;
    end else begin
      perf_cycles_q <= perf_cycles_q + 32'd1;
      if (StallD) begin
        perf_stalls_q <= perf_stalls_q + 32'd1;
      end
      if (FlushD | FlushE) begin
        perf_flushes_q <= perf_flushes_q + 32'd1;
      end
      if (ValidW) begin
        perf_retired_q <= perf_retired_q + 32'd1;
      end
    end
  end

  assign PerfCycles  = perf_cycles_q;
  assign PerfStalls  = perf_stalls_q;
  assign PerfFlushes = perf_flushes_q;
  assign PerfRetired = perf_retired_q;
`else
  assign PerfCycles  = '0;
  assign PerfStalls  = '0;
  assign PerfFlushes = '0;
  assign PerfRetired = '0;
`endif

endmodule

// File: tb/tb_pipe_stage_regs.sv
// Randomized bench for pipe_stage_regs against a slot-based model.
// Instructions move as whole slots; flush/stall rules act on slots.
module tb_pipe_stage_regs;
  import pipe_pkg::*;

  localparam logic [31:0] RST_PC = 32'h0000_0000;
  localparam logic [31:0] LW_X5  = 32'h0000_2283;
  localparam logic [31:0] ADD_X6 = 32'h0012_8333;

  typedef logic [191:0] w_t;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] PCNextF, InstrF, ReadDataM;
  logic        StallF, StallD, FlushD, FlushE;
  ctrl_t       CtrlD;
  idex_t       DataD;
  exmem_t      DataE;
  logic [31:0] PCF, InstrD, PCD, PCPlus4D;
  logic [4:0]  Rs1D, Rs2D, RdD;
  ctrl_t       CtrlE, CtrlM, CtrlW;
  idex_t       DataE_q;
  exmem_t      DataM;
  memwb_t      DataW;
  logic [4:0]  Rs1E, Rs2E, RdE, RdM, RdW;
  logic        RegWriteM, RegWriteW, ResultSrcE0;
  logic        ValidD, ValidE, ValidM, ValidW;
  logic [31:0] PerfCycles, PerfStalls, PerfFlushes, PerfRetired;

  pipe_stage_regs #(
    .XLEN     (32),
    .RESET_PC (RST_PC)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .PCNextF     (PCNextF),
    .InstrF      (InstrF),
    .StallF      (StallF),
    .StallD      (StallD),
    .FlushD      (FlushD),
    .FlushE      (FlushE),
    .CtrlD       (CtrlD),
    .DataD       (DataD),
    .DataE       (DataE),
    .ReadDataM   (ReadDataM),
    .PCF         (PCF),
    .InstrD      (InstrD),
    .PCD         (PCD),
    .PCPlus4D    (PCPlus4D),
    .Rs1D        (Rs1D),
    .Rs2D        (Rs2D),
    .RdD         (RdD),
    .CtrlE       (CtrlE),
    .DataE_q     (DataE_q),
    .CtrlM       (CtrlM),
    .DataM       (DataM),
    .CtrlW       (CtrlW),
    .DataW       (DataW),
    .Rs1E        (Rs1E),
    .Rs2E        (Rs2E),
    .RdE         (RdE),
    .RdM         (RdM),
    .RdW         (RdW),
    .RegWriteM   (RegWriteM),
    .RegWriteW   (RegWriteW),
    .ResultSrcE0 (ResultSrcE0),
    .ValidD      (ValidD),
    .ValidE      (ValidE),
    .ValidM      (ValidM),
    .ValidW      (ValidW),
    .PerfCycles  (PerfCycles),
    .PerfStalls  (PerfStalls),
    .PerfFlushes (PerfFlushes),
    .PerfRetired (PerfRetired)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic        valid;
    logic [31:0] instr;
    logic [31:0] pc;
    logic [31:0] pc4;
    ctrl_t       ctrl;
    idex_t       d;
    exmem_t      x;
    logic [31:0] rdat;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [4:0]  rd;
  } slot_t;

  slot_t       md, me, mm, mw;
  logic [31:0] mpc;
  logic [31:0] m_cyc, m_stl, m_fl, m_ret;
  int          n_tests = 0;
  int          n_fail  = 0;

  task automatic chk(input string tag, input w_t got, input w_t exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic slot_t nop_slot();
    slot_t s;
    s       = '0;
    s.instr = NOP_INSTR;
    return s;
  endfunction

  task automatic model_edge();
    slot_t nd, ne, nm, nw;
    if (reset) begin
      mpc   = RST_PC;
      md    = nop_slot();
      me    = '0;
      mm    = '0;
      mw    = '0;
      m_cyc = '0;
      m_stl = '0;
      m_fl  = '0;
      m_ret = '0;
    end else begin
      m_cyc = m_cyc + 1;
      if (StallD) m_stl = m_stl + 1;
      if (FlushD || FlushE) m_fl = m_fl + 1;
      if (mw.valid) m_ret = m_ret + 1;
      nw      = mm;
      nw.rdat = ReadDataM;
      nm      = me;
      nm.x    = DataE;
      ne      = '0;
      if (!FlushE) begin
        ne      = md;
        ne.ctrl = CtrlD;
        ne.d    = DataD;
        ne.rs1  = md.instr[19:15];
        ne.rs2  = md.instr[24:20];
        ne.rd   = md.instr[11:7];
      end
      nd = md;
      if (FlushD) begin
        nd = nop_slot();
      end else if (!StallD) begin
        nd       = '0;
        nd.valid = 1'b1;
        nd.instr = InstrF;
        nd.pc    = mpc;
        nd.pc4   = mpc + 4;
      end
      if (!StallF) mpc = PCNextF;
      md = nd;
      me = ne;
      mm = nm;
      mw = nw;
    end
  endtask

  task automatic check_all();
    chk("pcf", w_t'(PCF), w_t'(mpc));
    chk("instr_d", w_t'(InstrD), w_t'(md.instr));
    chk("valid_d", w_t'(ValidD), w_t'(md.valid));
    chk("pc_d", w_t'(PCD), w_t'(md.pc));
    if (md.valid) chk("pc4_d", w_t'(PCPlus4D), w_t'(md.pc4));
    chk("rs1_d", w_t'(Rs1D), w_t'(md.instr[19:15]));
    chk("rs2_d", w_t'(Rs2D), w_t'(md.instr[24:20]));
    chk("rd_d", w_t'(RdD), w_t'(md.instr[11:7]));
    chk("valid_e", w_t'(ValidE), w_t'(me.valid));
    chk("ctrl_e", w_t'(CtrlE), w_t'(me.ctrl));
    chk("rs1_e", w_t'(Rs1E), w_t'(me.rs1));
    chk("rs2_e", w_t'(Rs2E), w_t'(me.rs2));
    chk("rd_e", w_t'(RdE), w_t'(me.rd));
    chk("res0_e", w_t'(ResultSrcE0), w_t'(me.ctrl.result_src[0]));
    if (me.valid) chk("data_e", w_t'(DataE_q), w_t'(me.d));
    chk("valid_m", w_t'(ValidM), w_t'(mm.valid));
    chk("ctrl_m", w_t'(CtrlM), w_t'(mm.ctrl));
    chk("rd_m", w_t'(RdM), w_t'(mm.rd));
    chk("rw_m", w_t'(RegWriteM), w_t'(mm.ctrl.reg_write));
    if (mm.valid) chk("data_m", w_t'(DataM), w_t'(mm.x));
    chk("valid_w", w_t'(ValidW), w_t'(mw.valid));
    chk("ctrl_w", w_t'(CtrlW), w_t'(mw.ctrl));
    chk("rd_w", w_t'(RdW), w_t'(mw.rd));
    chk("rw_w", w_t'(RegWriteW), w_t'(mw.ctrl.reg_write));
    if (mw.valid) begin
      chk("alu_w", w_t'(DataW.alu_result), w_t'(mw.x.alu_result));
      chk("rdat_w", w_t'(DataW.read_data), w_t'(mw.rdat));
      chk("pc4_w", w_t'(DataW.pc_plus4), w_t'(mw.x.pc_plus4));
    end
`ifdef PIPE_PERF_CNT_EN
    chk("perf_cyc", w_t'(PerfCycles), w_t'(m_cyc));
    chk("perf_stl", w_t'(PerfStalls), w_t'(m_stl));
    chk("perf_fl", w_t'(PerfFlushes), w_t'(m_fl));
    chk("perf_ret", w_t'(PerfRetired), w_t'(m_ret));
`else
    chk("perf_cyc0", w_t'(PerfCycles), w_t'(0));
    chk("perf_stl0", w_t'(PerfStalls), w_t'(0));
    chk("perf_fl0", w_t'(PerfFlushes), w_t'(0));
    chk("perf_ret0", w_t'(PerfRetired), w_t'(0));
`endif
  endtask

  task automatic cycle();
    @(posedge clk);
    model_edge();
    #1;
    check_all();
  endtask

  task automatic rand_data();
    PCNextF   = $urandom();
    InstrF    = $urandom();
    CtrlD     = ctrl_t'(11'($urandom()));
    DataD     = {$urandom(), $urandom(), $urandom(), $urandom(), $urandom()};
    DataE     = {$urandom(), $urandom(), $urandom()};
    ReadDataM = $urandom();
  endtask

  task automatic no_hazard();
    StallF = 1'b0;
    StallD = 1'b0;
    FlushD = 1'b0;
    FlushE = 1'b0;
  endtask

  initial begin
    logic [31:0] pc_hold;
    reset = 1'b1;
    no_hazard();
    rand_data();
    md = nop_slot();
    me = '0;
    mm = '0;
    mw = '0;
    mpc = RST_PC;
    m_cyc = '0;
    m_stl = '0;
    m_fl = '0;
    m_ret = '0;

    cycle();
    cycle();
    chk("rst_pcf", w_t'(PCF), w_t'(RST_PC));
    chk("rst_instr", w_t'(InstrD), w_t'(NOP_INSTR));

    reset = 1'b0;
    for (int k = 1; k <= 4; k++) begin
      rand_data();
      PCNextF = mpc + 4;
      cycle();
      chk("rel_pcf", w_t'(PCF), w_t'(4 * k));
      chk("vw_rise", w_t'(ValidW), w_t'(k >= 4));
    end

    rand_data();
    InstrF = LW_X5;
    cycle();
    rand_data();
    InstrF = ADD_X6;
    CtrlD = '{reg_write: 1'b1, result_src: 2'b01, default: '0};
    cycle();
    chk("lu_res0", w_t'(ResultSrcE0), w_t'(1));
    chk("lu_rde5", w_t'(RdE), w_t'(5));
    rand_data();
    pc_hold = mpc;
    StallF = 1'b1;
    StallD = 1'b1;
    FlushE = 1'b1;
    cycle();
    chk("lu_pcf", w_t'(PCF), w_t'(pc_hold));
    chk("lu_instr", w_t'(InstrD), w_t'(ADD_X6));
    chk("lu_vale", w_t'(ValidE), w_t'(0));
    chk("lu_rde0", w_t'(RdE), w_t'(0));
    no_hazard();
    rand_data();
    CtrlD = '{reg_write: 1'b1, default: '0};
    cycle();
    chk("lu_add_rd", w_t'(RdE), w_t'(6));
    chk("lu_add_rs1", w_t'(Rs1E), w_t'(5));
    chk("lu_add_val", w_t'(ValidE), w_t'(1));

    rand_data();
    PCNextF = 32'h0000_0040;
    FlushD = 1'b1;
    FlushE = 1'b1;
    cycle();
    chk("br_instr", w_t'(InstrD), w_t'(NOP_INSTR));
    chk("br_vald", w_t'(ValidD), w_t'(0));
    chk("br_vale", w_t'(ValidE), w_t'(0));
    chk("br_pcf", w_t'(PCF), w_t'(32'h40));

    no_hazard();
    rand_data();
    cycle();
    rand_data();
    StallD = 1'b1;
    FlushD = 1'b1;
    cycle();
    chk("sf_instr", w_t'(InstrD), w_t'(NOP_INSTR));

    no_hazard();
    rand_data();
    StallF = 1'b1;
    StallD = 1'b1;
    cycle();
    rand_data();
    reset = 1'b1;
    cycle();
    chk("rms_pcf", w_t'(PCF), w_t'(RST_PC));
    chk("rms_vald", w_t'(ValidD), w_t'(0));
    reset = 1'b0;
    no_hazard();

`ifdef PIPE_PERF_CNT_EN
    reset = 1'b1;
    cycle();
    reset = 1'b0;
    for (int i = 0; i < 10; i++) begin
      rand_data();
      no_hazard();
      StallF = (i == 3) || (i == 6);
      StallD = (i == 3) || (i == 6);
      FlushD = (i == 8);
      cycle();
    end
    chk("pc_cyc10", w_t'(PerfCycles), w_t'(10));
    chk("pc_stl2", w_t'(PerfStalls), w_t'(2));
    chk("pc_fl1", w_t'(PerfFlushes), w_t'(1));
    no_hazard();
    dut.perf_cycles_q = 32'hFFFF_FFFF;
    m_cyc = 32'hFFFF_FFFF;
    cycle();
    chk("pc_wrap", w_t'(PerfCycles), w_t'(0));
`endif

    for (int i = 0; i < 400; i++) begin
      rand_data();
      reset  = ($urandom_range(0, 49) == 0);
      StallD = ($urandom_range(0, 5) == 0);
      StallF = StallD | ($urandom_range(0, 9) == 0);
      FlushD = ($urandom_range(0, 7) == 0);
      FlushE = ($urandom_range(0, 7) == 0);
      cycle();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
